sgd_result_packer: RTL and testbench

Upstream feeder for the HBM send-back stage. Accepts a stream of 32-bit SGD results (model or gradient words) from the compute engine. Packs them eight at a time into 256-bit beats and pads every job to a whole number of 64-byte DMA lines. Announces each job with a start pulse, destination address and byte length, and throttles the engine against the send-back FIFO's almost-full flag.

---
 rtl/sgd_result_packer.sv | 171 +++++++++++++++++
 tb/tb_sgd_result_packer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_result_packer.sv
// sgd_result_packer: packs 32-bit SGD results eight at a time into 256-bit beats,
// pads each job to whole 64-byte lines and announces it to the HBM send-back stage.
module sgd_result_packer #(
    parameter logic [31:0] PAD_VALUE = 32'h0000_0000
) (
    input  logic         hbm_clk,
    input  logic         hbm_aresetn,
    input  logic         cfg_start,
    input  logic [63:0]  cfg_addr,
    input  logic [31:0]  cfg_num_words,
    input  logic [31:0]  s_result_data,
    input  logic         s_result_valid,
    output logic         s_result_ready,
    output logic         back_start,
    output logic [63:0]  back_addr_x,
    output logic [31:0]  back_data_length,
    output logic [255:0] back_data,
    output logic         back_valid,
    input  logic         back_almost_full,
    output logic         busy,
    output logic         done,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ANNOUNCE = 3'd1,
        ST_PACK     = 3'd2,
        ST_PAD      = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [2:0]   lane_idx;
    logic [31:0]  words_left;
    logic [23:0]  beats_sent;
    logic [23:0]  target_beats;
    logic [255:0] lane_buf;
    logic [255:0] beat_next;
    logic [22:0]  job_lines;

    logic         job_go;
    logic         word_accept;
    logic         last_word;
    logic         beat_close;
    logic         pad_issue;
    logic         pad_last;

    // Number of 64-byte lines in the job: ceil(num_words / 16) over the supported 26-bit range.
    assign job_lines = 23'((32'(cfg_num_words[25:0]) + 32'd15) >> 4);

    // s_result handshake: a word transfers on each rising edge where valid and ready are
    // both high; the producer holds valid and data until then. Ready drops combinationally
    // with back_almost_full.
    assign job_go      = (state == ST_IDLE) && cfg_start;
    assign word_accept = s_result_valid && s_result_ready;
    assign last_word   = (words_left == 32'd1);
    assign beat_close  = word_accept && ((lane_idx == 3'd7) || last_word);
    assign pad_last    = ((beats_sent + 24'd1) >= target_beats);
    assign pad_issue   = (state == ST_PAD) && !back_almost_full && (beats_sent != target_beats);

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_next = (cfg_num_words == 32'd0) ? ST_FINISH : ST_ANNOUNCE;
                end
            end
            ST_ANNOUNCE: state_next = ST_PACK;
            ST_PACK: begin
                if (word_accept && last_word) begin
                    state_next = pad_last ? ST_FINISH : ST_PAD;
                end
            end
            ST_PAD: begin
                if (pad_issue && pad_last) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_result_ready = 1'b0;
        back_start     = 1'b0;
        case (state)
            ST_ANNOUNCE: back_start     = 1'b1;
            ST_PACK:     s_result_ready = !back_almost_full;
            default:     ;
        endcase
    end

    assign dbg_state = state;

    // Beat as it would look if closed this cycle: stored lanes, the incoming word, then padding.
    always_comb begin
        beat_next = '0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) < lane_idx) begin
                beat_next[32*k +: 32] = lane_buf[32*k +: 32];
            end else if (3'(k) == lane_idx) begin
                beat_next[32*k +: 32] = s_result_data;
            end else begin
                beat_next[32*k +: 32] = PAD_VALUE;
            end
        end
    end

    // busy and done are registered views of the state, so both trail it by one cycle
    // and fall together.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            back_addr_x      <= '0;
            back_data_length <= '0;
            back_data        <= '0;
            back_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            lane_idx         <= '0;
            words_left       <= '0;
            beats_sent       <= '0;
            target_beats     <= '0;
            lane_buf         <= '0;
        end else begin
            back_valid <= beat_close || pad_issue;
            busy       <= (state != ST_IDLE);
            done       <= (state == ST_FINISH);

            if (job_go) begin
                back_data_length <= {3'b000, job_lines, 6'b000000};
                target_beats     <= {job_lines, 1'b0};
                words_left       <= cfg_num_words;
                beats_sent       <= '0;
                lane_idx         <= '0;
                if (cfg_num_words != 32'd0) begin
                    back_addr_x <= cfg_addr;
                end
            end

            if (word_accept) begin
                lane_buf[{lane_idx, 5'd0} +: 32] <= s_result_data;
                words_left <= words_left - 32'd1;
                lane_idx   <= lane_idx + 3'd1;
                if (beat_close) begin
                    back_data  <= beat_next;
                    lane_idx   <= 3'd0;
                    beats_sent <= beats_sent + 24'd1;
                end
            end

            if (pad_issue) begin
                back_data  <= {8{PAD_VALUE}};
                beats_sent <= beats_sent + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_sgd_result_packer.sv
// tb_sgd_result_packer: drives packing jobs with random gaps and almost-full, and scores
// every beat and job announcement against a queue-based model of the packing rules.
module tb_sgd_result_packer;

    logic         hbm_clk = 1'b0;
    logic         hbm_aresetn;
    logic         cfg_start;
    logic [63:0]  cfg_addr;
    logic [31:0]  cfg_num_words;
    logic [31:0]  s_result_data;
    logic         s_result_valid;
    logic         s_result_ready;
    logic         back_start;
    logic [63:0]  back_addr_x;
    logic [31:0]  back_data_length;
    logic [255:0] back_data;
    logic         back_valid;
    logic         back_almost_full;
    logic         busy;
    logic         done;
    logic [2:0]   dbg_state;

    sgd_result_packer dut (
        .hbm_clk          (hbm_clk),
        .hbm_aresetn      (hbm_aresetn),
        .cfg_start        (cfg_start),
        .cfg_addr         (cfg_addr),
        .cfg_num_words    (cfg_num_words),
        .s_result_data    (s_result_data),
        .s_result_valid   (s_result_valid),
        .s_result_ready   (s_result_ready),
        .back_start       (back_start),
        .back_addr_x      (back_addr_x),
        .back_data_length (back_data_length),
        .back_data        (back_data),
        .back_valid       (back_valid),
        .back_almost_full (back_almost_full),
        .busy             (busy),
        .done             (done),
        .dbg_state        (dbg_state)
    );

    // Clock and cycle counter
    always #5 hbm_clk = ~hbm_clk;

    int cyc = 0;
    always @(posedge hbm_clk) cyc <= cyc + 1;

    // Scoreboard state
    int           checks = 0;
    int           failures = 0;
    logic [255:0] exp_q[$];
    logic [255:0] got_q[$];
    logic [31:0]  word_q[$];
    logic [63:0]  exp_addr;
    logic [31:0]  exp_len;
    bit           exp_announce = 0;
    int           acc_cnt = 0;
    int           gap_pct = 0;
    int           af_pct = 0;
    bit           af_force = 0;
    bit           prev_af = 0;
    int           cfg_cyc, start_cnt, start_cyc, bv_cnt, last_bv_cyc;
    int           done_cnt, done_cyc, busy_cnt, last_busy_cyc, first_rdy_cyc;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pin_beat(input string name, input int idx, input logic [255:0] lit);
        if (idx < got_q.size()) begin
            check(name, got_q[idx], lit);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: beat %0d missing, got %0d beats", name, idx, got_q.size());
        end
    endtask

    // Word driver: holds valid until accepted, inserts random gaps between words.
    initial begin : feeder
        bit accepted;
        s_result_valid = 1'b0;
        s_result_data  = '0;
        forever begin
            @(negedge hbm_clk);
            accepted = s_result_valid && s_result_ready;
            @(posedge hbm_clk);
            #1;
            if (accepted && word_q.size() > 0) begin
                void'(word_q.pop_front());
                acc_cnt++;
            end
            if (word_q.size() == 0) begin
                s_result_valid = 1'b0;
            end else if (!(s_result_valid && !accepted)) begin
                s_result_valid = ($urandom_range(0, 99) >= gap_pct);
            end
            s_result_data = s_result_valid ? word_q[0] : $urandom;
        end
    end

    // Almost-full driver: forced high for directed stalls, otherwise random.
    initial begin : af_driver
        back_almost_full = 1'b0;
        forever begin
            @(posedge hbm_clk);
            #1;
            back_almost_full = af_force || (af_pct > 0 && $urandom_range(0, 99) < af_pct);
        end
    end

    // Compare process: every cycle, checks beats, announce fields and backpressure rules.
    initial begin : compare
        logic [255:0] e;
        forever begin
            @(negedge hbm_clk);
            if (hbm_aresetn) begin
                if (back_almost_full) check("ready_under_af", s_result_ready, 0);
                if (prev_af) check("beat_after_af", back_valid, 0);
                if (s_result_ready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
                if (back_valid) begin
                    bv_cnt++;
                    last_bv_cyc = cyc;
                    got_q.push_back(back_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got %0h expected no beat (cycle %0d)", back_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", back_data, e);
                    end
                end
                if (back_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                if (exp_announce && (busy || back_start)) begin
                    check("addr_hold", back_addr_x, exp_addr);
                    check("len_hold", back_data_length, exp_len);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy) begin
                    busy_cnt++;
                    last_busy_cyc = cyc;
                end
                prev_af = back_almost_full;
            end else begin
                prev_af = 1'b0;
            end
        end
    end

    task automatic clear_job_counters();
        start_cnt = 0; start_cyc = -1; bv_cnt = 0; last_bv_cyc = -1;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; last_busy_cyc = -1;
        first_rdy_cyc = -1;
        got_q.delete();
    endtask

    // Model: words padded with PAD_VALUE (0) to a multiple of 16, split into 8-lane beats.
    task automatic start_job(input int n, input logic [63:0] addr, input bit seq, input logic [31:0] base);
        logic [31:0]  wl[$];
        logic [255:0] beat;
        int           lines;
        @(posedge hbm_clk);
        #1;
        for (int i = 0; i < n; i++) begin
            wl.push_back(seq ? base + 32'(i) + 32'd1 : $urandom);
            word_q.push_back(wl[i]);
        end
        lines = (n + 15) / 16;
        for (int b = 0; b < 2 * lines; b++) begin
            beat = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < n) beat[32*k +: 32] = wl[b * 8 + k];
            end
            exp_q.push_back(beat);
        end
        exp_addr     = addr;
        exp_len      = 32'(lines * 64);
        exp_announce = (n != 0);
        clear_job_counters();
        cfg_start     = 1'b1;
        cfg_addr      = addr;
        cfg_num_words = 32'(n);
        cfg_cyc       = cyc;
        @(posedge hbm_clk);
        #1;
        cfg_start     = 1'b0;
        cfg_addr      = {$urandom, $urandom};
        cfg_num_words = $urandom;
    endtask

    task automatic end_job(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge hbm_clk);
            k++;
        end
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: no done after %0d cycles", budget);
        end
        repeat (3) @(posedge hbm_clk);
        #1;
        check("done_count", 32'(done_cnt), 1);
        check("start_count", 32'(start_cnt), exp_announce ? 1 : 0);
        check("beat_count", 32'(bv_cnt), exp_len / 32);
        check("beats_left", 32'(exp_q.size()), 0);
        check("words_left", 32'(word_q.size()), 0);
        if (exp_announce) begin
            check("start_cycle", 32'(start_cyc - cfg_cyc), 1);
            check("done_after_beat", 32'(done_cyc - last_bv_cyc), 1);
        end else begin
            check("empty_done_cycle", 32'(done_cyc - cfg_cyc), 2);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(done_cyc - cfg_cyc - 1));
        check("busy_falls_with_done", 32'(last_busy_cyc), 32'(done_cyc));
        af_pct = 0;
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge hbm_clk);
        hbm_aresetn = 1'b0;
        word_q.delete();
        exp_q.delete();
        exp_announce = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge hbm_clk);
            check("rst_ready", s_result_ready, 0);
            check("rst_start", back_start, 0);
            check("rst_addr", back_addr_x, 0);
            check("rst_len", back_data_length, 0);
            check("rst_data", back_data, 0);
            check("rst_valid", back_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end
        hbm_aresetn = 1'b1;
    endtask

    task automatic wait_words(input int target);
        int k = 0;
        while (!(acc_cnt == target) && k < 500) begin
            @(negedge hbm_clk);
            k++;
        end
        if (k >= 500) begin
            checks++;
            failures++;
            $display("FAIL word_wait: only %0d words accepted, needed %0d", acc_cnt, target);
        end
    endtask

    task automatic run_t1_pins(input string tag);
        check({tag, "_len"}, back_data_length, 32'd64);
        check({tag, "_addr"}, back_addr_x, 64'h1000);
        check({tag, "_first_ready"}, 32'(first_rdy_cyc - cfg_cyc), 2);
        pin_beat({tag, "_beat0"}, 0, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        pin_beat({tag, "_beat1"}, 1, 256'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009);
    endtask

    // Main sequence
    initial begin : main
        int base;
        int n;
        int dir_sizes[8] = '{1, 7, 8, 9, 15, 17, 24, 33};
        hbm_aresetn   = 1'b0;
        cfg_start     = 1'b0;
        cfg_addr      = '0;
        cfg_num_words = '0;
        clear_job_counters();
        apply_reset(3);

        // 16 words, no backpressure
        start_job(16, 64'h1000, 1, 32'd0);
        end_job(200);
        run_t1_pins("t1");

        // 3 words: one data beat plus one padding beat
        start_job(3, 64'h2040, 1, 32'd9);
        end_job(200);
        check("t2_len", back_data_length, 32'd64);
        check("t2_pulses", 32'(bv_cnt), 2);
        pin_beat("t2_beat0", 0, 256'h00000000_00000000_00000000_00000000_00000000_0000000c_0000000b_0000000a);
        pin_beat("t2_beat1", 1, 256'h0);

        // 20 words, with an ignored cfg_start mid-job
        start_job(20, 64'h0000_0001_0000_3000, 1, 32'd0);
        repeat (5) @(posedge hbm_clk);
        #1;
        cfg_start = 1'b1; cfg_addr = 64'hDEAD_BEEF_0000_0040; cfg_num_words = 32'd5;
        @(posedge hbm_clk);
        #1;
        cfg_start = 1'b0;
        end_job(200);
        check("t3_len", back_data_length, 32'd128);
        check("t3_addr", back_addr_x, 64'h0000_0001_0000_3000);
        check("t3_pulses", 32'(bv_cnt), 4);
        pin_beat("t3_beat2", 2, 256'h00000000_00000000_00000000_00000000_00000014_00000013_00000012_00000011);
        pin_beat("t3_beat3", 3, 256'h0);

        // 32 words, almost-full held for 10 cycles after word 5
        start_job(32, 64'h4000, 0, 32'd0);
        base = acc_cnt;
        begin
            int k = 0;
            while (!(acc_cnt == base + 4 && s_result_valid && s_result_ready) && k < 200) begin
                @(negedge hbm_clk);
                k++;
            end
        end
        af_force = 1'b1;
        repeat (10) begin
            @(negedge hbm_clk);
            check("stall_ready", s_result_ready, 0);
            check("stall_valid", back_valid, 0);
        end
        af_force = 1'b0;
        end_job(300);
        check("t4_pulses", 32'(bv_cnt), 4);

        // Empty job
        start_job(0, 64'h5000, 0, 32'd0);
        end_job(50);
        check("t5_len", back_data_length, 32'd0);
        check("t5_pulses", 32'(bv_cnt), 0);
        check("t5_busy", 32'(busy_cnt), 1);

        // Reset after 5 words, then a clean repeat of the first job
        start_job(16, 64'h7000, 0, 32'd0);
        wait_words(acc_cnt + 5);
        apply_reset(3);
        start_job(16, 64'h1000, 1, 32'd0);
        end_job(200);
        run_t1_pins("t6");

        // Largest supported job: length only, then abort
        @(posedge hbm_clk);
        #1;
        clear_job_counters();
        exp_addr = 64'h0000_00AB_CDEF_0000; exp_len = 32'h0FFF_FFC0; exp_announce = 1;
        cfg_start = 1'b1; cfg_addr = exp_addr; cfg_num_words = 32'h03FF_FFF0;
        @(posedge hbm_clk);
        #1;
        cfg_start = 1'b0;
        repeat (3) @(posedge hbm_clk);
        #1;
        check("max_len", back_data_length, 32'h0FFF_FFC0);
        check("max_start", 32'(start_cnt), 1);
        apply_reset(2);

        // Boundary sizes with random gaps and almost-full
        foreach (dir_sizes[i]) begin
            gap_pct = $urandom_range(0, 40);
            af_pct  = $urandom_range(0, 30);
            start_job(dir_sizes[i], {$urandom, $urandom}, 0, 32'd0);
            end_job(2000);
        end

        // Random jobs
        for (int j = 0; j < 25; j++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 48);
            gap_pct = $urandom_range(0, 50);
            af_pct  = $urandom_range(0, 40);
            start_job(n, {$urandom, $urandom}, 0, 32'd0);
            end_job(3000);
        end

        gap_pct = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
